tan_job_sequencer: RTL and testbench
====================================

Name: tan_job_sequencer

Overview:
Upstream feeder and result collector for the tan core (the start/x/busy/ready/y CORDIC-style unit).
- Buffers incoming angles (16-bit unsigned fraction, value = x·2^-16 rad) in a small FIFO.
- Launches one core computation at a time using the core's start/busy/ready handshake.
- Returns each tan result paired with its angle as a one-cycle result pulse, with timeout error detection.

Parameters:
DEPTH, 4, FIFO entries (power of 2, ≥2)
W, 16, angle/result width (fraction bits)
START_HOLD, 8, max cycles core_start is held waiting for core_busy
TIMEOUT, 4095, max cycles in WAIT before abort

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous reset, active-low (rst=0 resets on clk edge)
in_valid  in  1  angle push request
in_data  in  W  angle to push
in_ready  out  1  FIFO not full (count != DEPTH)
core_start  out  1  start to tan core
core_x  out  W  angle to tan core, stable from LAUNCH until exit of WAIT
core_busy  in  1  core computing
core_ready  in  1  core result valid/idle
core_y  in  W  core result
res_valid  out  1  one-cycle result pulse
res_x  out  W  angle of returned result
res_y  out  W  tan result (possibly clamped, see feature)
level  out  $clog2(DEPTH)+1  FIFO occupancy
err_start  out  1  sticky: core never asserted busy within START_HOLD
err_timeout  out  1  sticky: WAIT exceeded TIMEOUT

Behaviour:
- Reset (rst=0 at edge): FIFO empty, level=0, state IDLE, core_start=0, core_x=0, res_valid=0, res_x=0, res_y=0, both err flags 0.
- Reset is honoured mid-job: core_start drops the next cycle, the job is lost and the FIFO is flushed.
- Push: accepted when in_valid && in_ready; in_ready comes from registered level only. A push while full is ignored, even if a pop happens the same cycle.
- Simultaneous push+pop with level in 1..DEPTH-1: level is unchanged.
- Read/write pointers wrap modulo DEPTH.
- FSM states:
  - IDLE: if level>0 && core_busy==0 → LAUNCH, latching core_x=head. Waiting for busy==0 protects against a core still running after our reset.
  - LAUNCH: core_start=1.
    - If core_busy==1 → WAIT, with core_start=0 from the next cycle.
    - If START_HOLD cycles elapse without busy → set err_start, pop/drop entry, → IDLE.
  - WAIT: core_start=0. On core_busy==0 && core_ready==1 → CAPTURE. A stale ready before busy is never used, because WAIT is entered only after busy is seen.
    - Cycle counter reaching TIMEOUT → set err_timeout, pop/drop, → IDLE.
  - CAPTURE (1 cycle): res_valid=1, res_x=core_x, res_y=core_y (registered), pop head → IDLE.
- res_x/res_y hold their values until the next CAPTURE.
- Minimum job latency in our cycles: IDLE→LAUNCH 1, + core busy latency, + 2 (WAIT exit, CAPTURE).
- Max one job in flight; strict FIFO order of results.

Optional Feature:
- Macro TAN_RANGE_CLAMP_EN.
- Defined: angles > 16'hC90F (π/4) are clamped to 16'hC90F at push time, so tan < 1 fits the W-bit fraction. The push-time clamp also sets an internal per-entry flag; when set, res_y is forced to 16'hFFFF at CAPTURE. res_x reports the clamped angle.
- Undefined: angles pass unmodified; res_y = core_y with no saturation (overflow wraps as the core produces it).

Decomposition:
- Package tan_seq_pkg: state enum (IDLE, LAUNCH, WAIT, CAPTURE), ANGLE_PI_4=16'hC90F, ANGLE_PI_8=16'h6487, SAT_ONE=16'hFFFF.
- One sub-module: tan_seq_fifo (parameterised DEPTH×(W+1) sync FIFO with level, push/pop, same rst).

Test Plan:
- Reset mid-WAIT with 3 entries queued → next cycle level=0, core_start=0, res_valid never pulses for the dropped jobs.
- Push 0, then 16'h6487 (π/8), into core model (busy 20 cycles) → two res_valid pulses, in order: res_x=0/res_y=0, then res_x=16'h6487/res_y≈16'h6A0A (tan π/8 ≈ 0.4142·2^16, ±2 LSB).
- Push 5 angles with DEPTH=4 while core busy → 5th push ignored (in_ready=0), level=4, exactly 4 results returned.
- Push and pop in the same cycle at level=2 → level stays 2; pointer wrap verified after 9 consecutive jobs.
- Core model never asserts busy → err_start=1 after 8 LAUNCH cycles, entry dropped, next entry launches. Core model holds busy 5000 cycles → err_timeout=1.
- With TAN_RANGE_CLAMP_EN: push 16'hF000 → res_x=16'hC90F, res_y=16'hFFFF. Without it: res_x=16'hF000.

Source files
------------

// File: rtl/tan_seq_pkg.sv
// Shared types and angle constants for the tan job sequencer.
// The constants are 16-bit fractions of a radian (value = x * 2^-16).
package tan_seq_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LAUNCH  = 2'd1,
        WAIT    = 2'd2,
        CAPTURE = 2'd3
    } seq_state_t;

    localparam logic [15:0] ANGLE_PI_4 = 16'hC90F;
    localparam logic [15:0] ANGLE_PI_8 = 16'h6487;
    localparam logic [15:0] SAT_ONE    = 16'hFFFF;

endpackage

// File: rtl/tan_seq_fifo.sv
// Synchronous FIFO with an occupancy count, used to queue angles ahead of the tan core.
// A push while full is dropped even when a pop happens in the same cycle.
module tan_seq_fifo #(
    parameter int DEPTH = 4,
    parameter int DW    = 17
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_push,
    input  logic [DW-1:0]           i_data,
    input  logic                    i_pop,
    output logic [DW-1:0]           o_head,
    output logic [$clog2(DEPTH):0]  o_level,
    output logic                    o_full,
    output logic                    o_empty
);
    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0]  r_mem [DEPTH];
    logic [AW-1:0]  r_wptr;
    logic [AW-1:0]  r_rptr;
    logic [AW:0]    r_level;
    logic           w_do_push;
    logic           w_do_pop;

    // Full/empty come only from the registered level so in_ready never depends on a pop.
    assign o_full    = (r_level == (AW+1)'(DEPTH));
    assign o_empty   = (r_level == '0);
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;
    assign o_head    = r_mem[r_rptr];
    assign o_level   = r_level;

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wptr] <= i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_do_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_level <= r_level + (AW+1)'(1);
                2'b01:   r_level <= r_level - (AW+1)'(1);
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: rtl/tan_job_sequencer.sv
// Feeds queued angles to the tan core one job at a time and returns (angle, tan) result pulses.
// Build macro TAN_RANGE_CLAMP_EN clamps angles above pi/4 at push time and saturates their results.
module tan_job_sequencer
    import tan_seq_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int W          = 16,
    parameter int START_HOLD = 8,
    parameter int TIMEOUT    = 4095
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic [W-1:0]            in_data,
    output logic                    in_ready,
    output logic                    core_start,
    output logic [W-1:0]            core_x,
    input  logic                    core_busy,
    input  logic                    core_ready,
    input  logic [W-1:0]            core_y,
    output logic                    res_valid,
    output logic [W-1:0]            res_x,
    output logic [W-1:0]            res_y,
    output logic [$clog2(DEPTH):0]  level,
    output logic                    err_start,
    output logic                    err_timeout
);
    localparam int CMAX = (TIMEOUT > START_HOLD) ? TIMEOUT : START_HOLD;
    localparam int CW   = $clog2(CMAX + 1);

    seq_state_t     r_state;
    seq_state_t     w_next;
    logic [CW-1:0]  r_cnt;
    logic [W:0]     w_push_data;
    logic [W:0]     w_head;
    logic           w_full;
    logic           w_empty;
    logic           w_pop;
    logic           w_launch;
    logic           w_done;
    logic           w_err_start_set;
    logic           w_err_timeout_set;
    logic [W-1:0]   r_core_x;
    logic           r_flag;
    logic           r_res_valid;
    logic [W-1:0]   r_res_x;
    logic [W-1:0]   r_res_y;
    logic           r_err_start;
    logic           r_err_timeout;

`ifdef TAN_RANGE_CLAMP_EN
    logic w_clamp;
    assign w_clamp     = (in_data > W'(ANGLE_PI_4));
    assign w_push_data = w_clamp ? {1'b1, W'(ANGLE_PI_4)} : {1'b0, in_data};
`else
    assign w_push_data = {1'b0, in_data};
`endif

    tan_seq_fifo #(
        .DEPTH (DEPTH),
        .DW    (W + 1)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (in_valid),
        .i_data  (w_push_data),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_level (level),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_comb begin
        w_next            = r_state;
        w_pop             = 1'b0;
        w_launch          = 1'b0;
        w_done            = 1'b0;
        w_err_start_set   = 1'b0;
        w_err_timeout_set = 1'b0;
        case (r_state)
            IDLE: begin
                // A core still busy from before our reset must finish before we start it again.
                if (!w_empty && !core_busy) begin
                    w_next   = LAUNCH;
                    w_launch = 1'b1;
                end
            end
            LAUNCH: begin
                if (core_busy) begin
                    w_next = WAIT;
                end else if (r_cnt == CW'(START_HOLD - 1)) begin
                    w_err_start_set = 1'b1;
                    w_pop           = 1'b1;
                    w_next          = IDLE;
                end
            end
            WAIT: begin
                if (!core_busy && core_ready) begin
                    w_done = 1'b1;
                    w_next = CAPTURE;
                end else if (r_cnt == CW'(TIMEOUT - 1)) begin
                    w_err_timeout_set = 1'b1;
                    w_pop             = 1'b1;
                    w_next            = IDLE;
                end
            end
            CAPTURE: begin
                w_pop  = 1'b1;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // The cycle counter restarts on every state change so LAUNCH and WAIT each get their own budget.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            if (w_next != r_state || r_state == IDLE) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_core_x      <= '0;
            r_flag        <= 1'b0;
            r_res_valid   <= 1'b0;
            r_res_x       <= '0;
            r_res_y       <= '0;
            r_err_start   <= 1'b0;
            r_err_timeout <= 1'b0;
        end else begin
            if (w_launch) begin
                r_core_x <= w_head[W-1:0];
                r_flag   <= w_head[W];
            end
            r_res_valid <= w_done;
            if (w_done) begin
                r_res_x <= r_core_x;
                r_res_y <= r_flag ? W'(SAT_ONE) : core_y;
            end
            if (w_err_start_set) begin
                r_err_start <= 1'b1;
            end
            if (w_err_timeout_set) begin
                r_err_timeout <= 1'b1;
            end
        end
    end

    assign in_ready    = !w_full;
    assign core_start  = (r_state == LAUNCH);
    assign core_x      = r_core_x;
    assign res_valid   = r_res_valid;
    assign res_x       = r_res_x;
    assign res_y       = r_res_y;
    assign err_start   = r_err_start;
    assign err_timeout = r_err_timeout;

endmodule

// File: tb/tb_tan_job_sequencer.sv
// Scoreboard bench for tan_job_sequencer driving a behavioural tan core with configurable busy time.
module tb_tan_job_sequencer;

    typedef struct packed {
        logic [15:0] x;
        logic [15:0] y;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] in_data = '0;
    logic        in_ready;
    logic        core_start;
    logic [15:0] core_x;
    logic        core_busy = 1'b0;
    logic        core_ready = 1'b1;
    logic [15:0] core_y = '0;
    logic        res_valid;
    logic [15:0] res_x;
    logic [15:0] res_y;
    logic [2:0]  level;
    logic        err_start;
    logic        err_timeout;

    int   checkCount = 0;
    int   passCount = 0;
    exp_t sbQ[$];
    exp_t monExp;
    bit   timedOut;
    int   startCycles = 0;

    int          busyLen = 20;
    bit          neverBusy = 1'b0;
    bit          coreRunning = 1'b0;
    int          coreCnt = 0;
    logic [15:0] coreLatchedX = '0;

    tan_job_sequencer #(
        .DEPTH(4), .W(16), .START_HOLD(8), .TIMEOUT(4095)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .core_start(core_start), .core_x(core_x),
        .core_busy(core_busy), .core_ready(core_ready), .core_y(core_y),
        .res_valid(res_valid), .res_x(res_x), .res_y(res_y),
        .level(level), .err_start(err_start), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    // Hand-computed core answers: tan(0)=0, tan(pi/8)*2^16 = 0x6A0A; other angles get a marker value.
    function automatic logic [15:0] coreY(input logic [15:0] x);
        case (x)
            16'h0000: coreY = 16'h0000;
            16'h6487: coreY = 16'h6A0A;
            default:  coreY = x + 16'h1234;
        endcase
    endfunction

    // Behavioural tan core: busy for busyLen cycles after start, then ready with the result.
    always @(posedge clk) begin
        if (!coreRunning) begin
            if (core_start && !neverBusy) begin
                coreRunning  <= 1'b1;
                core_busy    <= 1'b1;
                core_ready   <= 1'b0;
                coreCnt      <= busyLen;
                coreLatchedX <= core_x;
            end
        end else if (coreCnt > 1) begin
            coreCnt <= coreCnt - 1;
        end else begin
            coreRunning <= 1'b0;
            core_busy   <= 1'b0;
            core_ready  <= 1'b1;
            core_y      <= coreY(coreLatchedX);
        end
    end

    always @(negedge clk) begin
        if (core_start) begin
            startCycles <= startCycles + 1;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    // Monitor: every result pulse is matched against the oldest expected entry.
    always @(negedge clk) begin
        if (res_valid) begin
            if (sbQ.size() == 0) begin
                checkOutput("res_unexpected", {31'd0, res_valid}, 32'd0);
            end else begin
                monExp = sbQ.pop_front();
                checkOutput("res_x", {16'd0, res_x}, {16'd0, monExp.x});
                checkOutput("res_y", {16'd0, res_y}, {16'd0, monExp.y});
            end
        end
    end

    task automatic applyStimulus(input logic [15:0] x, input bit expectRes);
        exp_t e;
        timedOut = 1'b1;
        for (int i = 0; i < 500; i++) begin
            if (in_ready) begin
                timedOut = 1'b0;
                break;
            end
            @(negedge clk);
        end
        if (timedOut) begin
            checkOutput("push_wait_timeout", {31'd0, timedOut}, 32'd0);
        end
        e.x = x;
        e.y = coreY(x);
`ifdef TAN_RANGE_CLAMP_EN
        if (x > 16'hC90F) begin
            e.x = 16'hC90F;
            e.y = 16'hFFFF;
        end
`endif
        if (expectRes) begin
            sbQ.push_back(e);
        end
        in_valid = 1'b1;
        in_data  = x;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic waitDrain(input int budget);
        timedOut = 1'b1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (sbQ.size() == 0 && level == 3'd0 && !core_start) begin
                timedOut = 1'b0;
                break;
            end
        end
        checkOutput("drain_timeout", {31'd0, timedOut}, 32'd0);
        repeat (4) @(negedge clk);
    endtask

    initial begin
        int snap;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("rst_level", {29'd0, level}, 32'd0);
        checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd1);
        checkOutput("rst_core_start", {31'd0, core_start}, 32'd0);
        checkOutput("rst_core_x", {16'd0, core_x}, 32'd0);
        checkOutput("rst_res_valid", {31'd0, res_valid}, 32'd0);
        checkOutput("rst_res_x", {16'd0, res_x}, 32'd0);
        checkOutput("rst_res_y", {16'd0, res_y}, 32'd0);
        checkOutput("rst_err_start", {31'd0, err_start}, 32'd0);
        checkOutput("rst_err_timeout", {31'd0, err_timeout}, 32'd0);

        $display("[TB] basic jobs 0 and pi/8");
        applyStimulus(16'h0000, 1'b1);
        applyStimulus(16'h6487, 1'b1);
        waitDrain(300);
        checkOutput("hold_res_x", {16'd0, res_x}, 32'h6487);
        checkOutput("hold_res_y", {16'd0, res_y}, 32'h6A0A);

        $display("[TB] overflow with five pushes");
        applyStimulus(16'h1000, 1'b1);
        applyStimulus(16'h2000, 1'b1);
        applyStimulus(16'h3000, 1'b1);
        applyStimulus(16'h4000, 1'b1);
        checkOutput("full_in_ready", {31'd0, in_ready}, 32'd0);
        checkOutput("full_level", {29'd0, level}, 32'd4);
        in_valid = 1'b1;
        in_data  = 16'h5000;
        @(negedge clk);
        in_valid = 1'b0;
        checkOutput("full_level_after", {29'd0, level}, 32'd4);
        waitDrain(500);

        $display("[TB] push and pop in the same cycle");
        applyStimulus(16'h0100, 1'b1);
        applyStimulus(16'h0200, 1'b1);
        timedOut = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (res_valid) begin
                timedOut = 1'b0;
                break;
            end
            @(negedge clk);
        end
        checkOutput("capture_wait_timeout", {31'd0, timedOut}, 32'd0);
        checkOutput("pp_level_before", {29'd0, level}, 32'd2);
        sbQ.push_back('{x: 16'h0300, y: coreY(16'h0300)});
        in_valid = 1'b1;
        in_data  = 16'h0300;
        @(negedge clk);
        in_valid = 1'b0;
        checkOutput("pp_level_after", {29'd0, level}, 32'd2);
        waitDrain(500);

        $display("[TB] nine consecutive jobs across pointer wrap");
        for (int i = 0; i < 9; i++) begin
            applyStimulus(16'h0400 + 16'(i * 16'h0111), 1'b1);
        end
        waitDrain(2000);

        $display("[TB] core never asserts busy");
        neverBusy = 1'b1;
        snap = startCycles;
        applyStimulus(16'h0A00, 1'b0);
        applyStimulus(16'h0B00, 1'b1);
        timedOut = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (err_start) begin
                timedOut = 1'b0;
                break;
            end
            @(negedge clk);
        end
        checkOutput("err_start_wait_timeout", {31'd0, timedOut}, 32'd0);
        checkOutput("err_start", {31'd0, err_start}, 32'd1);
        checkOutput("launch_cycles", 32'(startCycles - snap), 32'd8);
        checkOutput("level_after_drop", {29'd0, level}, 32'd1);
        neverBusy = 1'b0;
        waitDrain(300);

        $display("[TB] core stays busy past the timeout");
        busyLen = 5000;
        applyStimulus(16'h0C00, 1'b0);
        timedOut = 1'b1;
        for (int i = 0; i < 6000; i++) begin
            if (err_timeout) begin
                timedOut = 1'b0;
                break;
            end
            @(negedge clk);
        end
        checkOutput("err_timeout_wait_timeout", {31'd0, timedOut}, 32'd0);
        checkOutput("err_timeout", {31'd0, err_timeout}, 32'd1);
        checkOutput("level_after_timeout", {29'd0, level}, 32'd0);
        timedOut = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            if (!core_busy) begin
                timedOut = 1'b0;
                break;
            end
            @(negedge clk);
        end
        checkOutput("core_idle_wait_timeout", {31'd0, timedOut}, 32'd0);
        busyLen = 20;
        repeat (4) @(negedge clk);

        $display("[TB] out-of-range angle");
        applyStimulus(16'hF000, 1'b1);
        waitDrain(300);

        $display("[TB] reset while waiting on the core");
        applyStimulus(16'h0D00, 1'b0);
        applyStimulus(16'h0E00, 1'b0);
        applyStimulus(16'h0F00, 1'b0);
        timedOut = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (core_busy) begin
                timedOut = 1'b0;
                break;
            end
            @(negedge clk);
        end
        checkOutput("busy_wait_timeout", {31'd0, timedOut}, 32'd0);
        repeat (3) @(negedge clk);
        checkOutput("pre_rst_level", {29'd0, level}, 32'd3);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("mid_rst_level", {29'd0, level}, 32'd0);
        checkOutput("mid_rst_core_start", {31'd0, core_start}, 32'd0);
        checkOutput("mid_rst_err_start", {31'd0, err_start}, 32'd0);
        checkOutput("mid_rst_err_timeout", {31'd0, err_timeout}, 32'd0);
        rst = 1'b1;
        repeat (80) @(negedge clk);
        checkOutput("final_level", {29'd0, level}, 32'd0);
        checkOutput("scoreboard_left", 32'(sbQ.size()), 32'd0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
